// File: rtl/life_step_engine_pkg.sv
// Shared constants, FSM encoding and grid indexing for the life step engine.
package life_pkg;

   localparam int ROWS  = 5;
   localparam int COLS  = 7;
   localparam int CELLS = ROWS * COLS;
   localparam int IDX_W = 6;
   localparam int GEN_W = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Cell (r,c) lives at bit r*COLS+c; bit 0 is the top-left corner.
   function automatic int cell_index(input int r, input int c);
      return r * COLS + c;
   endfunction

endpackage

// File: rtl/life_step_engine_if.sv
// Handshake and grid bus between the sequencing controller and the step engine.
interface life_step_engine_if;
   import life_pkg::*;

   logic               start;
   logic [CELLS-1:0]   cur_state;
   logic               busy;
   logic               wren;
   logic [CELLS-1:0]   nxt_state;
   logic               done;
   logic [GEN_W-1:0]   gen_count;

   modport master (
      output start, cur_state,
      input  busy, wren, nxt_state, done, gen_count
   );

   modport slave (
      input  start, cur_state,
      output busy, wren, nxt_state, done, gen_count
   );

endinterface

// File: rtl/life_step_engine_neighbor_counter.sv
// Live 8-neighbour count for one cell; cells off the grid count as dead.
module neighbor_counter
   import life_pkg::*;
(
   input  logic [CELLS-1:0] i_grid,
   input  logic [IDX_W-1:0] i_idx,
   output logic [3:0]       o_count
);

   logic [3:0] w_count;

   // Unrolled over every cell position; only the one matching i_idx contributes.
   always_comb begin
      w_count = 4'd0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (i_idx == IDX_W'(cell_index(r, c))) begin
               for (int dr = -1; dr <= 1; dr++) begin
                  for (int dc = -1; dc <= 1; dc++) begin
                     if (!(dr == 0 && dc == 0) &&
                         (r + dr >= 0) && (r + dr < ROWS) &&
                         (c + dc >= 0) && (c + dc < COLS)) begin
                        w_count = w_count + {3'b000, i_grid[cell_index(r + dr, c + dc)]};
                     end
                  end
               end
            end
         end
      end
   end

   assign o_count = w_count;

endmodule

// File: rtl/life_step_engine.sv
// Serial Game-of-Life generation step: one cell per clock from a frozen snapshot.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; nxt_state holds the last result
// S_CALC  | evaluating cell r_idx from the snapshot, one per clock
// S_WRITE | result complete; wren strobes MemoryUnit for one cycle
// S_DONE  | done pulse; generation counter advances on leaving
module life_step_engine
   import life_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_arst,
   life_step_engine_if.slave  io_if
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CELLS-1:0]   r_snap;
   logic [CELLS-1:0]   r_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [GEN_W-1:0]   r_gen;

   logic               w_busy;
   logic               w_wren;
   logic               w_done;
   logic [3:0]         w_count;
   logic               w_cell_nxt;

   neighbor_counter u_nbr (
      .i_grid  (r_snap),
      .i_idx   (r_idx),
      .o_count (w_count)
   );

   assign w_cell_nxt = (w_count == 4'd3) || (r_snap[r_idx] && (w_count == 4'd2));

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_arst) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode and status strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b1;
      w_wren      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (io_if.start) w_state_nxt = S_CALC;
         end
         S_CALC: begin
            if (r_idx == LAST_IDX) w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            w_wren      = 1'b1;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Snapshot capture, in-place result build and generation count.
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         r_snap <= '0;
         r_nxt  <= '0;
         r_idx  <= '0;
         r_gen  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_if.start) begin
                  r_snap <= io_if.cur_state;
                  r_idx  <= '0;
               end
            end
            S_CALC: begin
               r_nxt[r_idx] <= w_cell_nxt;
               r_idx        <= r_idx + IDX_W'(1);
            end
            S_DONE: r_gen <= r_gen + GEN_W'(1);
            default: ;
         endcase
      end
   end

   assign io_if.busy      = w_busy;
   assign io_if.wren      = w_wren;
   assign io_if.done      = w_done;
   assign io_if.nxt_state = r_nxt;
   assign io_if.gen_count = r_gen;

endmodule

// File: tb/tb_life_step_engine.sv
// Directed-vector bench for life_step_engine.
module tb_life_step_engine;
   import life_pkg::*;

   logic clk = 1'b0;
   logic arst;

   life_step_engine_if u_if ();

   life_step_engine u_dut (
      .i_clk  (clk),
      .i_arst (arst),
      .io_if  (u_if.slave)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: plain step, 1: cur_state forced all-ones after E10, 2: start pulses at E5 and E20
   task automatic run_step(input string tag, input logic [34:0] grid, input logic [34:0] exp_grid,
                           input logic [15:0] exp_gen, input int mode);
      int wren_n  = 0;
      int wren_at = -1;
      int done_n  = 0;
      int done_at = -1;
      int busy_n  = 0;
      u_if.cur_state = grid;
      u_if.start     = 1'b1;
      tick();
      u_if.start = 1'b0;
      check({tag, "_busy_e0"}, 64'(u_if.busy), 64'd1);
      for (int k = 1; k <= 40; k++) begin
         if (mode == 2 && (k == 5 || k == 20)) u_if.start = 1'b1;
         if (mode == 1 && k == 11) u_if.cur_state = '1;
         tick();
         u_if.start = 1'b0;
         if (u_if.busy) busy_n++;
         if (u_if.wren) begin
            wren_n++;
            if (wren_at < 0) begin
               wren_at = k;
               check({tag, "_nxt_at_wren"}, 64'(u_if.nxt_state), 64'(exp_grid));
            end
         end
         if (u_if.done) begin
            done_n++;
            if (done_at < 0) done_at = k;
         end
      end
      check({tag, "_wren_count"}, 64'(wren_n), 64'd1);
      check({tag, "_wren_edge"}, 64'(wren_at), 64'd35);
      check({tag, "_done_count"}, 64'(done_n), 64'd1);
      check({tag, "_done_edge"}, 64'(done_at), 64'd36);
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'd36);
      check({tag, "_gen"}, 64'(u_if.gen_count), 64'(exp_gen));
      check({tag, "_nxt_hold"}, 64'(u_if.nxt_state), 64'(exp_grid));
   endtask

   task automatic reset_mid_op();
      int wren_n = 0;
      int done_n = 0;
      u_if.cur_state = 35'h0_0007_0000;
      u_if.start     = 1'b1;
      tick();
      u_if.start = 1'b0;
      for (int k = 1; k <= 15; k++) tick();
      arst = 1'b1;
      tick();
      check("midrst_busy", 64'(u_if.busy), 64'd0);
      check("midrst_wren", 64'(u_if.wren), 64'd0);
      check("midrst_done", 64'(u_if.done), 64'd0);
      check("midrst_nxt", 64'(u_if.nxt_state), 64'd0);
      check("midrst_gen", 64'(u_if.gen_count), 64'd0);
      arst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (u_if.wren) wren_n++;
         if (u_if.done) done_n++;
      end
      check("midrst_no_wren", 64'(wren_n), 64'd0);
      check("midrst_no_done", 64'(done_n), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      arst           = 1'b1;
      u_if.start     = 1'b1;
      u_if.cur_state = 35'h7_FFFF_FFFF;
      tick();
      tick();
      tick();
      check("rst_busy", 64'(u_if.busy), 64'd0);
      check("rst_wren", 64'(u_if.wren), 64'd0);
      check("rst_done", 64'(u_if.done), 64'd0);
      check("rst_nxt", 64'(u_if.nxt_state), 64'd0);
      check("rst_gen", 64'(u_if.gen_count), 64'd0);
      arst       = 1'b0;
      u_if.start = 1'b0;
      tick();
      check("idle_busy", 64'(u_if.busy), 64'd0);

      run_step("blinker_h", 35'h0_0007_0000, 35'h0_0102_0400, 16'd1, 0);
      run_step("blinker_v", 35'h0_0102_0400, 35'h0_0007_0000, 16'd2, 0);
      run_step("corner_block", 35'h0_0000_0183, 35'h0_0000_0183, 16'd3, 0);
      run_step("single_cell", 35'h0_0000_0001, 35'h0_0000_0000, 16'd4, 0);
      run_step("snap_iso", 35'h0_0007_0000, 35'h0_0102_0400, 16'd5, 1);
      run_step("start_busy", 35'h0_0007_0000, 35'h0_0102_0400, 16'd6, 2);

      reset_mid_op();
      run_step("after_rst", 35'h0_0007_0000, 35'h0_0102_0400, 16'd1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
